// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG health reader.
//   state_e        : reader FSM state, 2-bit encoding visible on state_o
//   DEF_*          : default health-test cutoffs and startup length
//   pack_lsb_first : shifts a new bit into the MSB so the earliest bit ends at bit 0
package trng_pkg;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_FAIL    = 2'd2
    } state_e;

    localparam int DEF_RCT_CUTOFF   = 32;
    localparam int DEF_APT_WINDOW   = 512;
    localparam int DEF_APT_CUTOFF   = 410;
    localparam int DEF_STARTUP_BITS = 1024;

    function automatic logic [7:0] pack_lsb_first(input logic [7:0] sr, input logic b);
        return {b, sr[7:1]};
    endfunction

endpackage

// File: rtl/trng_health_reader_if.sv
// Byte output handshake between the health reader and the downstream logic.
//   byte_out   : packed random byte, bit 0 = earliest accepted bit
//   byte_valid : byte_out holds a fresh byte
//   byte_ready : downstream accepts byte_out
// master = health reader side, slave = consumer side.
interface trng_health_reader_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_out, output byte_valid, input byte_ready);
    modport slave  (input byte_out, input byte_valid, output byte_ready);
endinterface

// File: rtl/trng_health_tests.sv
// Continuous health tests on the raw bit stream: repetition count (RCT) and
// adaptive proportion (APT), with sticky failure flags.
//   clk, rst_n  : clock, async active-low reset
//   sample_i    : a raw bit is taken this cycle
//   bit_i       : the raw bit
//   freeze_i    : hold all test state (reader is in FAIL)
//   clear_i     : synchronous clear of counters and flags
//   rct_fail_o  : sticky RCT failure
//   apt_fail_o  : sticky APT failure
//   fail_set_o  : this cycle's sample sets a failure flag (combinational)
module trng_health_tests
    import trng_pkg::*;
#(
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
    parameter int APT_WINDOW = DEF_APT_WINDOW,
    parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_i,
    input  logic bit_i,
    input  logic freeze_i,
    input  logic clear_i,
    output logic rct_fail_o,
    output logic apt_fail_o,
    output logic fail_set_o
);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int WW = $clog2(APT_WINDOW);
    localparam int MW = $clog2(APT_CUTOFF + 1);

    logic          last_vld_q, last_vld_d;
    logic          last_q, last_d;
    logic [RW-1:0] run_q, run_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          ref_q, ref_d;
    logic [MW-1:0] match_q, match_d;
    logic          rct_q, rct_d;
    logic          apt_q, apt_d;
    logic          take_s;

    // Once a flag is set the tests stop advancing, even before the FSM reaches FAIL.
    assign take_s = sample_i & ~freeze_i & ~rct_q & ~apt_q;

    // Next-state logic for both tests; clear wins over any sample.
    always_comb begin
        last_vld_d = last_vld_q;
        last_d     = last_q;
        run_d      = run_q;
        wcnt_d     = wcnt_q;
        ref_d      = ref_q;
        match_d    = match_q;
        rct_d      = rct_q;
        apt_d      = apt_q;
        if (clear_i) begin
            last_vld_d = 1'b0;
            last_d     = 1'b0;
            run_d      = '0;
            wcnt_d     = '0;
            ref_d      = 1'b0;
            match_d    = '0;
            rct_d      = 1'b0;
            apt_d      = 1'b0;
        end else if (take_s) begin
            if (last_vld_q && (bit_i == last_q)) begin
                if (run_q != RW'(RCT_CUTOFF)) begin
                    run_d = run_q + RW'(1);
                end else begin
                    run_d = run_q;
                end
            end else begin
                run_d      = RW'(1);
                last_d     = bit_i;
                last_vld_d = 1'b1;
            end
            if (run_d == RW'(RCT_CUTOFF)) begin
                rct_d = 1'b1;
            end else begin
                rct_d = rct_q;
            end
            // Window length is a power of two, so the counter wraps by itself.
            wcnt_d = wcnt_q + WW'(1);
            if (wcnt_q == '0) begin
                ref_d   = bit_i;
                match_d = MW'(1);
            end else if ((bit_i == ref_q) && (match_q != MW'(APT_CUTOFF))) begin
                match_d = match_q + MW'(1);
            end else begin
                match_d = match_q;
            end
            if (match_d == MW'(APT_CUTOFF)) begin
                apt_d = 1'b1;
            end else begin
                apt_d = apt_q;
            end
        end else begin
            rct_d = rct_q;
            apt_d = apt_q;
        end
    end

    // Health-test state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld_q <= 1'b0;
            last_q     <= 1'b0;
            run_q      <= '0;
            wcnt_q     <= '0;
            ref_q      <= 1'b0;
            match_q    <= '0;
            rct_q      <= 1'b0;
            apt_q      <= 1'b0;
        end else begin
            last_vld_q <= last_vld_d;
            last_q     <= last_d;
            run_q      <= run_d;
            wcnt_q     <= wcnt_d;
            ref_q      <= ref_d;
            match_q    <= match_d;
            rct_q      <= rct_d;
            apt_q      <= apt_d;
        end
    end

    assign rct_fail_o = rct_q;
    assign apt_fail_o = apt_q;
    assign fail_set_o = (rct_d & ~rct_q) | (apt_d & ~apt_q);

endmodule

// File: rtl/trng_health_reader.sv
// Consumer of the raw TRNG bit stream: health-tests every sample, discards a
// startup run, then packs bits LSB-first into bytes offered on a valid/ready bus.
// Any health failure halts output until clear_fail.
//   clk, rst_n       : clock, async active-low reset
//   ena              : block enable (raw_valid ignored when low)
//   raw_bit/raw_valid: raw bit strobe, no backpressure
//   clear_fail       : clear sticky flags and restart in STARTUP
//   bus              : byte_out / byte_valid / byte_ready handshake
//   rct_fail/apt_fail: sticky health failures
//   overrun          : sticky, a completed byte was dropped
//   state_o          : 0 STARTUP, 1 RUN, 2 FAIL
module trng_health_reader
    import trng_pkg::*;
#(
    parameter int RCT_CUTOFF   = DEF_RCT_CUTOFF,
    parameter int APT_WINDOW   = DEF_APT_WINDOW,
    parameter int APT_CUTOFF   = DEF_APT_CUTOFF,
    parameter int STARTUP_BITS = DEF_STARTUP_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        raw_bit,
    input  logic                        raw_valid,
    input  logic                        clear_fail,
    trng_health_reader_if.master        bus,
    output logic                        rct_fail,
    output logic                        apt_fail,
    output logic                        overrun,
    output logic [1:0]                  state_o
);
    localparam int SW = $clog2(STARTUP_BITS + 1);

    state_e        state_q;
    logic [7:0]    sr_q;
    logic [2:0]    bcnt_q;
    logic [SW-1:0] scnt_q;
    logic [7:0]    byte_q;
    logic          bvalid_q;
    logic          overrun_q;
    logic          sample_s;
    logic          fail_any_s;
    logic          fail_set_s;

    assign sample_s   = ena & raw_valid;
    assign fail_any_s = rct_fail | apt_fail;

    trng_health_tests #(
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_tests (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_i   (sample_s),
        .bit_i      (raw_bit),
        .freeze_i   (state_q == ST_FAIL),
        .clear_i    (clear_fail),
        .rct_fail_o (rct_fail),
        .apt_fail_o (apt_fail),
        .fail_set_o (fail_set_s)
    );

    // Reader FSM, byte packer and output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STARTUP;
            sr_q      <= 8'h00;
            bcnt_q    <= 3'd0;
            scnt_q    <= '0;
            byte_q    <= 8'h00;
            bvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else if (clear_fail) begin
            state_q   <= ST_STARTUP;
            sr_q      <= 8'h00;
            bcnt_q    <= 3'd0;
            scnt_q    <= '0;
            bvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                ST_STARTUP: begin
                    if (fail_any_s) begin
                        state_q <= ST_FAIL;
                    end else if (sample_s && !fail_set_s) begin
                        if (scnt_q == SW'(STARTUP_BITS - 1)) begin
                            state_q <= ST_RUN;
                            scnt_q  <= '0;
                            sr_q    <= 8'h00;
                            bcnt_q  <= 3'd0;
                        end else begin
                            scnt_q <= scnt_q + SW'(1);
                        end
                    end else begin
                        scnt_q <= scnt_q;
                    end
                end
                ST_RUN: begin
                    if (fail_any_s) begin
                        state_q  <= ST_FAIL;
                        bvalid_q <= 1'b0;
                        sr_q     <= 8'h00;
                        bcnt_q   <= 3'd0;
                    end else begin
                        if (bvalid_q && bus.byte_ready) begin
                            bvalid_q <= 1'b0;
                        end
                        // A sample that trips a test is not packed, so its byte never leaves.
                        if (sample_s && !fail_set_s) begin
                            sr_q   <= pack_lsb_first(sr_q, raw_bit);
                            bcnt_q <= bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7) begin
                                if (!bvalid_q || bus.byte_ready) begin
                                    byte_q   <= pack_lsb_first(sr_q, raw_bit);
                                    bvalid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_FAIL: begin
                    bvalid_q <= 1'b0;
                    sr_q     <= 8'h00;
                    bcnt_q   <= 3'd0;
                end
                default: begin
                    state_q <= ST_STARTUP;
                end
            endcase
        end
    end

    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = bvalid_q;
    assign overrun        = overrun_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_trng_health_reader.sv
// Directed bench: dut_a uses default health cutoffs, dut_b a 16-bit APT window
// with cutoff 13; both use a 16-bit startup and share the same stimulus.
module tb_trng_health_reader;

    logic       clk;
    logic       rst_n, ena, raw_bit, raw_valid, clear_fail, byte_ready;
    logic       rct_a, apt_a, ovr_a, rct_b, apt_b, ovr_b;
    logic [1:0] st_a, st_b;
    int         checks = 0;
    int         errors = 0;

    trng_health_reader_if ifa ();
    trng_health_reader_if ifb ();
    assign ifa.byte_ready = byte_ready;
    assign ifb.byte_ready = byte_ready;

    trng_health_reader #(.STARTUP_BITS(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw_bit(raw_bit), .raw_valid(raw_valid),
        .clear_fail(clear_fail), .bus(ifa), .rct_fail(rct_a), .apt_fail(apt_a),
        .overrun(ovr_a), .state_o(st_a)
    );

    trng_health_reader #(.STARTUP_BITS(16), .APT_WINDOW(16), .APT_CUTOFF(13)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw_bit(raw_bit), .raw_valid(raw_valid),
        .clear_fail(clear_fail), .bus(ifb), .rct_fail(rct_b), .apt_fail(apt_b),
        .overrun(ovr_b), .state_o(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       b;
        logic       v;
        logic       rdy;
        logic [1:0] st;
        logic       bv;
        logic [7:0] by;
    } vec_t;
    vec_t tbl [28];

    // {state, byte_valid, byte_out, rct_fail, apt_fail, overrun}
    function automatic logic [13:0] pk(input logic [1:0] s, input logic v, input logic [7:0] b,
                                       input logic r, input logic a, input logic o);
        return {s, v, b, r, a, o};
    endfunction

    function automatic logic [13:0] obs_a();
        return {st_a, ifa.byte_valid, ifa.byte_out, rct_a, apt_a, ovr_a};
    endfunction

    function automatic logic [13:0] obs_b();
        return {st_b, ifb.byte_valid, ifb.byte_out, rct_b, apt_b, ovr_b};
    endfunction

    // byte_out is only compared when a valid byte is expected, or when full is set.
    task automatic cmp(input string nm, input logic [13:0] act, input logic [13:0] exp, input logic full);
        logic [13:0] m;
        m = (full || exp[11]) ? 14'h3FFF : 14'h3807;
        checks++;
        if ((act & m) !== (exp & m)) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", nm, act & m, exp & m);
        end
    endtask

    task automatic chk2(input string nm, input logic [13:0] exp, input logic full);
        cmp({nm, "_a"}, obs_a(), exp, full);
        cmp({nm, "_b"}, obs_b(), exp, full);
    endtask

    task automatic drive(input logic b, input logic v, input logic rdy, input logic clr);
        raw_bit    = b;
        raw_valid  = v;
        byte_ready = rdy;
        clear_fail = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] by, input logic rdy_last);
        for (int k = 0; k < 8; k++) begin
            drive(by[k], 1'b1, (k == 7) ? rdy_last : 1'b0, 1'b0);
        end
    endtask

    initial begin
        ena = 1'b1; rst_n = 1'b0; raw_bit = 1'b0; raw_valid = 1'b0;
        clear_fail = 1'b0; byte_ready = 1'b0;

        // Startup on alternating bits, first byte 0xAA, hold while not ready, then drain.
        for (int i = 0; i < 24; i++) begin
            tbl[i].b   = 1'(i % 2);
            tbl[i].v   = 1'b1;
            tbl[i].rdy = 1'b0;
            tbl[i].st  = (i >= 15) ? 2'd1 : 2'd0;
            tbl[i].bv  = (i == 23) ? 1'b1 : 1'b0;
            tbl[i].by  = (i == 23) ? 8'hAA : 8'h00;
        end
        for (int i = 24; i < 28; i++) begin
            tbl[i].b   = 1'b0;
            tbl[i].v   = 1'b0;
            tbl[i].rdy = (i == 27) ? 1'b1 : 1'b0;
            tbl[i].st  = 2'd1;
            tbl[i].bv  = (i == 27) ? 1'b0 : 1'b1;
            tbl[i].by  = 8'hAA;
        end

        @(posedge clk); #1;
        chk2("reset", pk(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].b, tbl[i].v, tbl[i].rdy, 1'b0);
            chk2($sformatf("vec%0d", i), pk(tbl[i].st, tbl[i].bv, tbl[i].by, 1'b0, 1'b0, 1'b0), 1'b0);
        end

        // Overrun: first byte held, second dropped; then a load on the drain cycle.
        feed(8'h55, 1'b0);
        chk2("ovr_first", pk(2'd1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0), 1'b0);
        feed(8'h33, 1'b0);
        chk2("ovr_drop", pk(2'd1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1), 1'b0);
        feed(8'h5A, 1'b1);
        chk2("load_on_drain", pk(2'd1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1), 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk2("drain", pk(2'd1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1), 1'b0);

        // RCT: 32 ones after a 0, downstream always ready (dut_a only).
        for (int k = 1; k <= 32; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            if (k == 8)  cmp("rct_byte_ff", obs_a(), pk(2'd1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1), 1'b0);
            if (k == 31) cmp("rct_31", obs_a(), pk(2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1), 1'b0);
            if (k == 32) cmp("rct_32", obs_a(), pk(2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1), 1'b0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        cmp("rct_fail_state", obs_a(), pk(2'd2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1), 1'b0);
        for (int k = 0; k < 8; k++) drive(1'(k % 2), 1'b1, 1'b1, 1'b0);
        cmp("fail_ignores", obs_a(), pk(2'd2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1), 1'b0);

        // clear_fail together with a sample: the sample must not count toward startup.
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk2("clear", pk(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), 1'b0);
        for (int k = 0; k < 16; k++) begin
            drive(1'(k % 2), 1'b1, 1'b0, 1'b0);
            if (k == 14) chk2("restart_15", pk(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), 1'b0);
            if (k == 15) chk2("restart_16", pk(2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), 1'b0);
        end
        feed(8'hAA, 1'b0);
        chk2("restart_byte", pk(2'd1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0), 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between clock edges, mid-byte with byte_valid high.
        raw_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk2("async_reset", pk(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // APT on dut_b: 12 matching zeros pass, 13 trip on the last bit of the window.
        for (int k = 0; k < 16; k++) drive(1'((k % 4) == 3), 1'b1, 1'b0, 1'b0);
        chk2("apt_w12", pk(2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), 1'b0);
        for (int k = 0; k < 16; k++) begin
            drive(1'((k == 3) || (k == 7) || (k == 11)), 1'b1, 1'b0, 1'b0);
            if (k == 14) chk2("apt_w13_pre", pk(2'd1, 1'b1, 8'h88, 1'b0, 1'b0, 1'b0), 1'b0);
            if (k == 15) begin
                cmp("apt_w13_a", obs_a(), pk(2'd1, 1'b1, 8'h88, 1'b0, 1'b0, 1'b1), 1'b0);
                cmp("apt_trip_b", {11'd0, st_b, apt_b}, {11'd0, 2'd1, 1'b1}, 1'b1);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        cmp("apt_fail_state_b", {10'd0, st_b, ifb.byte_valid, apt_b}, {10'd0, 2'd2, 1'b0, 1'b1}, 1'b1);

        // clear_fail still acts with ena low.
        ena = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk2("ena0_clear", pk(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), 1'b0);
        ena = 1'b1;
        clear_fail = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trng_health_reader.md
Name: trng_health_reader

Overview:
- Consumer end of the SR-latch TRNG's raw bit stream.
- Samples raw bits, runs continuous health tests on them: repetition count (RCT) and adaptive proportion (APT).
- Packs accepted bits into bytes and offers them through a valid/ready handshake to the downstream register or IO logic.
- Sits between the TRNG core and the tile's output mux. On any health failure it stops emitting bytes until software clears the failure.

Parameters:
- RCT_CUTOFF, 32, run length of identical bits that trips rct_fail (2..255).
- APT_WINDOW, 512, APT window length in bits (power of two, 16..1024).
- APT_CUTOFF, 410, count of bits matching the window's first bit that trips apt_fail (must be < APT_WINDOW).
- STARTUP_BITS, 1024, raw bits consumed and discarded after reset or clear before output is enabled.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  block enable; when low, raw_valid is ignored and all state holds
- raw_bit  input  1  raw TRNG bit
- raw_valid  input  1  raw_bit is valid this cycle; one-cycle strobe, no backpressure
- clear_fail  input  1  synchronous pulse: clear sticky flags, restart in STARTUP
- byte_out  output  8  packed random byte, bit 0 = earliest accepted bit
- byte_valid  output  1  byte_out holds a fresh byte
- byte_ready  input  1  downstream accepts byte_out
- rct_fail  output  1  sticky RCT failure
- apt_fail  output  1  sticky APT failure
- overrun  output  1  sticky: a completed byte was dropped because the holding register was full
- state_o  output  2  current FSM state: 0 STARTUP, 1 RUN, 2 FAIL

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0, state STARTUP;
  - shift register, bit count, RCT and APT counters cleared;
  - RCT "last bit" invalid.
- Sample: a raw bit is taken when ena & raw_valid. All counters advance only on a sample.
- RCT:
  - first sample after reset or clear sets last=bit, run=1;
  - afterwards, bit==last increments run (saturating at RCT_CUTOFF); else run=1, last=bit;
  - run reaching RCT_CUTOFF sets rct_fail in the same cycle as that sample's register update.
- APT:
  - wcnt counts 0..APT_WINDOW-1 and wraps;
  - at wcnt==0, ref=bit and match=1;
  - otherwise match increments when bit==ref, saturating at APT_CUTOFF;
  - match reaching APT_CUTOFF sets apt_fail;
  - match resets only at window start.
- Health tests run in STARTUP and RUN. Tests freeze in FAIL.
- FSM:
  - STARTUP: discard bits and count them. After STARTUP_BITS samples with no failure, go to RUN with the shift register empty.
  - RUN: pack bits LSB-first. On the 8th bit, load byte_out and set byte_valid if the holding register is empty or is being drained this cycle (byte_valid & byte_ready). Otherwise drop the byte and set overrun.
  - Any state except FAIL: rct_fail or apt_fail becoming set goes to FAIL on the next cycle.
  - FAIL: byte_valid forced 0, holding register and partial byte discarded, raw samples ignored.
  - clear_fail (any state): clears rct_fail, apt_fail, overrun, all counters, partial byte and byte_valid, then goes to STARTUP.
- Handshake:
  - byte_valid stays high and byte_out stays stable until byte_ready.
  - Transfer happens on the cycle where byte_valid & byte_ready. byte_valid then drops unless a new byte loads that same cycle.
  - The byte completing on the same cycle as the failing sample is not delivered.
- Simultaneous events:
  - clear_fail overrides a sample and a failure in the same cycle.
  - ena=0 with clear_fail still clears.
- Latency: the 8th accepted bit appears in byte_out/byte_valid on the next clock edge. Throughput is at most 1 byte per 8 samples.
- Widths:
  - run counter ceil(log2(RCT_CUTOFF+1)) bits;
  - wcnt log2(APT_WINDOW);
  - match ceil(log2(APT_CUTOFF+1));
  - startup counter ceil(log2(STARTUP_BITS+1)).

Decomposition:
- Package trng_pkg: state enum (STARTUP, RUN, FAIL) as 2-bit encoding, and default cutoff constants.
- One natural sub-module, trng_health_tests: RCT+APT counters and sticky fail flags. It takes sample, bit, freeze and clear, and drives rct_fail and apt_fail.
- The packer and FSM stay in the top module.

Test Plan:
- Reset then alternating 0/1 bits with STARTUP_BITS=16 → no fails; bytes 0xAA appear after 16+8 samples; byte_valid held while byte_ready=0.
- 32 consecutive 1s in RUN → rct_fail=1 on the 32nd sample; state_o=2 next cycle; byte_valid=0; later samples ignored.
- APT_WINDOW=16, APT_CUTOFF=13, window of bits that are 0 except every 4th bit, first bit 0 (12 zeros) → no fail. Same with 13 zeros → apt_fail=1.
- byte_ready=0 for 16 samples in RUN → first byte held, second dropped, overrun=1, byte_out unchanged.
- clear_fail pulsed in FAIL, simultaneous with raw_valid → flags 0, state_o=0, that sample not counted, startup restarts.
- rst_n asserted mid-byte with byte_valid=1 → all outputs 0 immediately, asynchronous to clk.
